wb_timer: RTL and testbench
===========================

// Module: wb_timer
// PURPOSE
//  Wishbone slave timer on the IO bus behind the IO MMU, occupying the io_timer port.
//  Holds a 32-bit up-counter with optional prescale and four compare channels.
//  Each channel has an optional periodic reload and a sticky match flag.
//  Drives a 4-bit interrupt vector that feeds the CPU inter[3:0] input.
// PARAMETERS
//  NCHAN     4   compare channels, 1..4; unused channels read 0 and never fire
//  PS_WIDTH  16  prescaler width in bits; only meaningful with TIMER_PRESCALE_EN
// PORTS
//  clk_i      in   1    system clock (clk_sys); the only clock
//  rst_i      in   1    reset, asynchronous, active-high
//  bus        slave if_wb  32-bit pipelined Wishbone port
//    signals used: cyc, stb, we, sel[3:0], adr, dat_i, dat_o, ack, stall
//    adr[3:0] is the word index
//  interrupt  out  4    per-channel level interrupt; bit n = STATUS[n] & IE[n]
// BEHAVIOUR
//  Register map (word index, 32-bit):
//   0 CTRL      [0] RUN; [7:4] IE per channel
//   1 STATUS    [3:0] sticky match flags; write 1 to clear, writing 0 has no effect
//   2 COUNT     r/w counter value
//   3 PRESCALE  [PS_WIDTH-1:0]
//   4-7 CMPn
//   8-11 INTn, the reload interval; 0 = one-shot
//   12-15       unmapped: read 0, writes ignored
//  Bus handshake:
//   - stall is tied 0.
//   - ack is asserted exactly 1 cycle after each cycle with cyc&stb, and never without cyc.
//   - Back-to-back strobes produce back-to-back acks.
//   - Read data is registered and valid in the cycle ack is high.
//   - Writes honour sel byte lanes; unselected bytes are unchanged.
//   - Writes take effect on the ack cycle edge, i.e. they are visible to a read issued the next cycle.
//  Tick:
//   - tick = RUN & (prescaler at terminal count). Without the macro, tick = RUN.
//   - On tick, COUNT <= COUNT + 1 mod 2^32. 0xFFFFFFFF wraps to 0 with no flag.
//  Match:
//   - Fires for channel n when tick=1 and COUNT+1 == CMPn.
//   - A software write to COUNT never fires a match.
//   - On match: STATUS[n] <= 1.
//   - If INTn != 0, CMPn <= CMPn + INTn mod 2^32.
//  Interrupts:
//   - interrupt is registered and rises 1 cycle after the match edge.
//   - It stays high until the flag is cleared or IE is cleared.
//  Collisions in one cycle:
//   - A hardware match and a STATUS W1C on the same bit: the set wins, so the flag stays 1.
//   - A CPU write to COUNT and a tick: the CPU value is loaded, with no increment and no match.
//   - A CPU write to CMPn and a reload: the CPU value wins.
//   - All channels are evaluated independently; several flags may set in one cycle.
//  Reset: the following outputs and registers take the listed values.
//   - ack 0, dat_o 0, interrupt 0.
//   - All registers 0, prescaler count 0.
//   - A bus cycle in flight at reset is dropped; no ack is issued for it.
// CONFIGURATION
//  TIMER_PRESCALE_EN defined:
//   - PRESCALE is r/w.
//   - The internal prescale counter counts 0..PRESCALE, and tick fires at PRESCALE.
//   - The tick period is PRESCALE+1 clocks.
//   - The prescale counter resets to 0 on a PRESCALE write and while RUN=0.
//  TIMER_PRESCALE_EN undefined:
//   - No prescaler logic is built; tick = RUN every clock.
//   - Index 3 reads 0 and writes are ignored.
// TESTING
//  1. After reset, read idx 0..11 -> all 0, ack 1 clk after each stb, interrupt=0.
//  2. CMP0=10, CTRL=0x11 -> interrupt[0] rises 11 clks after RUN set.
//     STATUS=0x1 clears it. With INT0=0, nothing more fires.
//  3. CMP1=5, INT1=5, IE1 -> STATUS[1] sets at COUNT=5,10,15; CMP1 reads 20 after the 3rd match.
//  4. COUNT=0xFFFFFFFE, RUN -> wraps 0xFFFFFFFF then 0, no flags.
//     Then CMP2=0: the next wrap to 0 sets STATUS[2].
//  5. Collisions, each in one cycle:
//     - W1C STATUS[0] with match 0 -> flag stays 1.
//     - COUNT write with tick -> written value, no match.
//     - sel=4'b0010 write to CMP3 -> only bits [15:8] change.
//  6. (TIMER_PRESCALE_EN) PRESCALE=3 -> COUNT steps every 4 clks.
//     Undefined: write 3 to idx 3 -> reads 0, COUNT steps every clk.

Source files
------------

// File: rtl/wb_timer.sv
// wb_timer: Wishbone slave timer with a 32-bit up-counter and NCHAN compare/reload channels.
// Define TIMER_PRESCALE_EN to build the programmable prescaler behind word index 3.
module wb_timer #(
  parameter int NCHAN    = 4,
  parameter int PS_WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic [3:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [3:0]  interrupt
);

  if (NCHAN < 1 || NCHAN > 4) begin : g_bad_nchan
    $error("wb_timer: NCHAN must be in 1..4");
  end
  if (PS_WIDTH < 1 || PS_WIDTH > 32) begin : g_bad_ps_width
    $error("wb_timer: PS_WIDTH must be in 1..32");
  end

  function automatic logic [31:0] f_merge(input logic [31:0] old,
                                          input logic [31:0] wdat,
                                          input logic [3:0]  sel);
    return {sel[3] ? wdat[31:24] : old[31:24],
            sel[2] ? wdat[23:16] : old[23:16],
            sel[1] ? wdat[15:8]  : old[15:8],
            sel[0] ? wdat[7:0]   : old[7:0]};
  endfunction

  logic              w_req;
  logic              w_wr;
  logic              w_wr_ctrl;
  logic              w_wr_status;
  logic              w_wr_count;
  logic              w_tick;
  logic [31:0]       w_count_inc;
  logic [3:0]        w_match;
  logic [3:0]        w_clr;
  logic [3:0][31:0]  w_cmp;
  logic [3:0][31:0]  w_int;
  logic [31:0]       w_ps_rd;
  logic [31:0]       w_rdata;

  logic              r_ack;
  logic              r_run;
  logic [3:0]        r_ie;
  logic [3:0]        r_status;
  logic [3:0]        r_irq;
  logic [31:0]       r_count;

  assign w_req       = i_wb_cyc & i_wb_stb;
  assign w_wr        = w_req & i_wb_we;
  assign w_wr_ctrl   = w_wr & (i_wb_adr == 4'd0);
  assign w_wr_status = w_wr & (i_wb_adr == 4'd1);
  assign w_wr_count  = w_wr & (i_wb_adr == 4'd2);
  assign w_count_inc = r_count + 32'd1;
  assign w_clr       = (w_wr_status & i_wb_sel[0]) ? i_wb_dat[3:0] : '0;

  assign o_wb_ack    = r_ack & i_wb_cyc;
  assign o_wb_stall  = 1'b0;
  assign interrupt   = r_irq;

`ifdef TIMER_PRESCALE_EN
  logic                w_wr_ps;
  logic [PS_WIDTH-1:0] r_prescale;
  logic [PS_WIDTH-1:0] r_ps_cnt;

  assign w_wr_ps = w_wr & (i_wb_adr == 4'd3);
  assign w_tick  = r_run & (r_ps_cnt == r_prescale);
  assign w_ps_rd = 32'(r_prescale);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prescale <= '0;
      r_ps_cnt   <= '0;
    end else begin
      if (w_wr_ps)
        r_prescale <= PS_WIDTH'(f_merge(32'(r_prescale), i_wb_dat, i_wb_sel));
      if (!r_run || w_wr_ps || (r_ps_cnt == r_prescale))
        r_ps_cnt <= '0;
      else
        r_ps_cnt <= r_ps_cnt + 1'b1;
    end
  end
`else
  assign w_tick  = r_run;
  assign w_ps_rd = '0;
`endif

  // A CPU write to COUNT suppresses the match; a CPU write to CMPn overrides its reload.
  for (genvar g = 0; g < 4; g++) begin : g_ch
    if (g < NCHAN) begin : g_on
      logic        w_wr_cmp;
      logic        w_wr_int;
      logic [31:0] r_cmp;
      logic [31:0] r_int;

      assign w_wr_cmp   = w_wr & (i_wb_adr == 4'(4 + g));
      assign w_wr_int   = w_wr & (i_wb_adr == 4'(8 + g));
      assign w_match[g] = w_tick & ~w_wr_count & (w_count_inc == r_cmp);
      assign w_cmp[g]   = r_cmp;
      assign w_int[g]   = r_int;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_cmp <= '0;
          r_int <= '0;
        end else begin
          if (w_wr_cmp)
            r_cmp <= f_merge(r_cmp, i_wb_dat, i_wb_sel);
          else if (w_match[g] && (r_int != '0))
            r_cmp <= r_cmp + r_int;
          if (w_wr_int)
            r_int <= f_merge(r_int, i_wb_dat, i_wb_sel);
        end
      end
    end else begin : g_off
      assign w_match[g] = 1'b0;
      assign w_cmp[g]   = '0;
      assign w_int[g]   = '0;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (i_wb_adr)
      4'd0:                    w_rdata = {24'd0, r_ie, 3'd0, r_run};
      4'd1:                    w_rdata = {28'd0, r_status};
      4'd2:                    w_rdata = r_count;
      4'd3:                    w_rdata = w_ps_rd;
      4'd4, 4'd5, 4'd6, 4'd7:  w_rdata = w_cmp[i_wb_adr[1:0]];
      4'd8, 4'd9, 4'd10, 4'd11: w_rdata = w_int[i_wb_adr[1:0]];
      default:                 w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack    <= 1'b0;
      o_wb_dat <= '0;
      r_run    <= 1'b0;
      r_ie     <= '0;
      r_status <= '0;
      r_count  <= '0;
      r_irq    <= '0;
    end else begin
      r_ack <= w_req;
      if (w_req)
        o_wb_dat <= w_rdata;
      if (w_wr_ctrl && i_wb_sel[0]) begin
        r_run <= i_wb_dat[0];
        r_ie  <= i_wb_dat[7:4];
      end
      // Hardware set wins over a same-cycle write-1-to-clear.
      r_status <= (r_status & ~w_clr) | w_match;
      if (w_wr_count)
        r_count <= f_merge(r_count, i_wb_dat, i_wb_sel);
      else if (w_tick)
        r_count <= w_count_inc;
      r_irq <= r_status & r_ie;
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: vector table, directed corner sequences and
// randomized bus traffic checked against a cycle-level behavioural model.
module tb_wb_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel, adr;
  logic [31:0] wdat, rdat;
  logic        ack, stall;
  logic [3:0]  irq;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_timer #(.NCHAN(4), .PS_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_sel(sel),
    .i_wb_adr(adr), .i_wb_dat(wdat), .o_wb_dat(rdat),
    .o_wb_ack(ack), .o_wb_stall(stall), .interrupt(irq)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_count;
  logic [31:0] m_cmp [4];
  logic [31:0] m_int [4];
  logic [31:0] m_ps;
  logic [31:0] m_phase;
  logic        m_run;
  logic [3:0]  m_ie;
  logic [3:0]  m_status;

  function automatic void model_reset();
    m_count = 0; m_ps = 0; m_phase = 0; m_run = 0; m_ie = 0; m_status = 0;
    for (int n = 0; n < 4; n++) begin m_cmp[n] = 0; m_int[n] = 0; end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'd0: return {24'd0, m_ie, 3'd0, m_run};
      4'd1: return {28'd0, m_status};
      4'd2: return m_count;
`ifdef TIMER_PRESCALE_EN
      4'd3: return m_ps;
`endif
      4'd4, 4'd5, 4'd6, 4'd7:   return m_cmp[a[1:0]];
      4'd8, 4'd9, 4'd10, 4'd11: return m_int[a[1:0]];
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge: timer rules first, then CPU writes override.
  function automatic void model_edge(input logic rq, input logic w, input logic [3:0] a,
                                     input logic [31:0] d, input logic [3:0] s);
    logic        wr, tick;
    logic [3:0]  match, clr;
    logic [31:0] wv;
    wr = rq && w;
    wv = merge(model_read(a), d, s);
`ifdef TIMER_PRESCALE_EN
    tick = m_run && (m_phase == m_ps);
    if (!m_run || (wr && a == 4'd3)) m_phase = 0;
    else if (m_phase == m_ps)        m_phase = 0;
    else                             m_phase = m_phase + 1;
`else
    tick = m_run;
`endif
    match = 0;
    for (int n = 0; n < 4; n++)
      if (tick && !(wr && a == 4'd2) && (m_count + 32'd1 == m_cmp[n])) match[n] = 1'b1;
    for (int n = 0; n < 4; n++)
      if (match[n] && m_int[n] != 0) m_cmp[n] = m_cmp[n] + m_int[n];
    if (tick) m_count = m_count + 32'd1;
    clr = (wr && a == 4'd1 && s[0]) ? d[3:0] : 4'd0;
    m_status = (m_status & ~clr) | match;
    if (wr) begin
      case (a)
        4'd0: if (s[0]) begin m_run = wv[0]; m_ie = wv[7:4]; end
        4'd2: m_count = wv;
`ifdef TIMER_PRESCALE_EN
        4'd3: m_ps = wv & 32'h0000FFFF;
`endif
        4'd4, 4'd5, 4'd6, 4'd7:   m_cmp[a[1:0]] = wv;
        4'd8, 4'd9, 4'd10, 4'd11: m_int[a[1:0]] = wv;
        default: ;
      endcase
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; drives one cycle and checks the response at the next negedge.
  task automatic step(input logic rq, input logic w, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic [3:0]  exp_irq;
    cyc = rq; stb = rq; we = w; adr = a; wdat = d; sel = s;
    exp_rd  = model_read(a);
    exp_irq = m_status & m_ie;
    model_edge(rq, w, a, d, s);
    @(negedge clk);
    chk("ack", {31'd0, ack}, {31'd0, rq});
    if (rq && !w) chk("rdata", rdat, exp_rd);
    chk("irq", {28'd0, irq}, {28'd0, exp_irq});
    rd = rdat;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] x;
    step(1'b1, 1'b1, a, d, 4'hF, x);
  endtask

  task automatic rdv(input logic [3:0] a, output logic [31:0] d);
    step(1'b1, 1'b0, a, 32'd0, 4'hF, d);
  endtask

  task automatic idle();
    logic [31:0] x;
    step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, x);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] rd;
  int          first;
  int          det[$];
  logic        pend;
  int unsigned ci;
  logic [3:0]  ra;
  logic        rw;
  logic [3:0]  rs;
  logic [31:0] rdv_d;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---- vector table ----
    for (int i = 0; i < 16; i++) tbl.push_back('{1'b0, 4'(i), 32'd0, 4'hF, 32'd0});
    tbl.push_back('{1'b1, 4'd7,  32'h11223344, 4'hF, 32'd0});
    tbl.push_back('{1'b0, 4'd7,  32'd0,        4'hF, 32'h11223344});
    tbl.push_back('{1'b1, 4'd7,  32'hAABBCCDD, 4'b0010, 32'd0});
    tbl.push_back('{1'b0, 4'd7,  32'd0,        4'hF, 32'h1122CC44});
    tbl.push_back('{1'b1, 4'd10, 32'hDEADBEEF, 4'b1100, 32'd0});
    tbl.push_back('{1'b0, 4'd10, 32'd0,        4'hF, 32'hDEAD0000});
    tbl.push_back('{1'b1, 4'd12, 32'hFFFFFFFF, 4'hF, 32'd0});
    tbl.push_back('{1'b0, 4'd12, 32'd0,        4'hF, 32'd0});
    tbl.push_back('{1'b1, 4'd3,  32'd3,        4'hF, 32'd0});
`ifdef TIMER_PRESCALE_EN
    tbl.push_back('{1'b0, 4'd3,  32'd0,        4'hF, 32'd3});
`else
    tbl.push_back('{1'b0, 4'd3,  32'd0,        4'hF, 32'd0});
`endif
    tbl.push_back('{1'b1, 4'd0,  32'hFFFFFFFE, 4'hF, 32'd0});
    tbl.push_back('{1'b0, 4'd0,  32'd0,        4'hF, 32'h000000F0});
    tbl.push_back('{1'b1, 4'd2,  32'h12345678, 4'b0101, 32'd0});
    tbl.push_back('{1'b0, 4'd2,  32'd0,        4'hF, 32'h00340078});
    tbl.push_back('{1'b1, 4'd1,  32'hF,        4'hF, 32'd0});
    tbl.push_back('{1'b0, 4'd1,  32'd0,        4'hF, 32'd0});
    tbl.push_back('{1'b1, 4'd0,  32'd0,        4'hF, 32'd0});
    tbl.push_back('{1'b1, 4'd2,  32'd0,        4'hF, 32'd0});
    tbl.push_back('{1'b1, 4'd3,  32'd0,        4'hF, 32'd0});
    tbl.push_back('{1'b1, 4'd7,  32'd0,        4'hF, 32'd0});
    tbl.push_back('{1'b1, 4'd10, 32'd0,        4'hF, 32'd0});
    tbl.push_back('{1'b0, 4'd0,  32'd0,        4'hF, 32'd0});

    // ---- reset ----
    rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_irq", {28'd0, irq}, 32'd0);
    chk("stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(1'b1, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd);
      if (!tbl[i].we) chk("tbl_rd", rd, tbl[i].exp);
    end

    // ---- one-shot compare: interrupt 11 clocks after RUN ----
    wr(4'd4, 32'd10); wr(4'd8, 32'd0); wr(4'd2, 32'd0); wr(4'd0, 32'h11);
    first = -1;
    for (int j = 1; j <= 30; j++) begin
      idle();
      if (first < 0 && irq[0]) first = j;
    end
    chk("oneshot_latency", 32'(first), 32'd11);
    wr(4'd1, 32'h1);
    repeat (20) idle();
    rdv(4'd1, rd);
    chk("oneshot_cleared", rd, 32'd0);

    // ---- periodic reload ----
    wr(4'd0, 32'd0); wr(4'd1, 32'hF); wr(4'd2, 32'd0);
    wr(4'd5, 32'd5); wr(4'd9, 32'd5); wr(4'd0, 32'h21);
    pend = 1'b0;
    for (int j = 1; j <= 40 && det.size() < 3; j++) begin
      if (pend) begin
        wr(4'd1, 32'h2); pend = 1'b0;
      end else begin
        rdv(4'd1, rd);
        if (rd[1]) begin det.push_back(j); pend = 1'b1; end
      end
    end
    chk("reload_count", 32'(det.size()), 32'd3);
    for (int k = 0; k < det.size(); k++) chk("reload_when", 32'(det[k]), 32'(5 * (k + 1) + 1));
    wr(4'd1, 32'h2);
    rdv(4'd5, rd);
    chk("reload_cmp", rd, 32'd20);
    wr(4'd0, 32'd0);

    // ---- counter wrap ----
    wr(4'd6, 32'd5); wr(4'd7, 32'h100); wr(4'd1, 32'hF);
    wr(4'd2, 32'hFFFFFFFE); wr(4'd0, 32'h1);
    rdv(4'd2, rd); chk("wrap_a", rd, 32'hFFFFFFFE);
    rdv(4'd2, rd); chk("wrap_b", rd, 32'hFFFFFFFF);
    rdv(4'd2, rd); chk("wrap_c", rd, 32'd0);
    wr(4'd0, 32'd0);
    rdv(4'd1, rd); chk("wrap_noflag", rd, 32'd0);
    wr(4'd2, 32'hFFFFFFFE); wr(4'd6, 32'd0); wr(4'd0, 32'h1);
    idle(); idle();
    rdv(4'd1, rd); chk("wrap_cmp2", rd, 32'h4);
    wr(4'd0, 32'd0); wr(4'd1, 32'hF);

    // ---- collision: W1C with match ----
    wr(4'd2, 32'd0); wr(4'd4, 32'd3); wr(4'd8, 32'd0); wr(4'd1, 32'hF); wr(4'd0, 32'h1);
    idle(); idle();
    wr(4'd1, 32'h1);
    rdv(4'd1, rd); chk("w1c_vs_set", rd, 32'h1);
    wr(4'd0, 32'd0);

    // ---- collision: COUNT write with tick ----
    wr(4'd1, 32'hF); wr(4'd2, 32'd0); wr(4'd0, 32'h1);
    idle(); idle();
    wr(4'd2, 32'h50);
    rdv(4'd2, rd); chk("cntwr_value", rd, 32'h50);
    rdv(4'd1, rd); chk("cntwr_nomatch", rd, 32'd0);
    wr(4'd0, 32'd0);

    // ---- collision: CMP write with reload, two channels in one cycle ----
    wr(4'd1, 32'hF); wr(4'd2, 32'd0); wr(4'd5, 32'd3); wr(4'd9, 32'd5); wr(4'd0, 32'h1);
    idle(); idle();
    wr(4'd5, 32'h99);
    rdv(4'd5, rd); chk("cmpwr_wins", rd, 32'h99);
    rdv(4'd1, rd); chk("multi_flag", rd, 32'h3);
    wr(4'd0, 32'd0);

    // ---- prescale ----
    wr(4'd1, 32'hF); wr(4'd2, 32'd0); wr(4'd4, 32'h1000); wr(4'd5, 32'h1000);
    wr(4'd3, 32'd3);
    rdv(4'd3, rd);
`ifdef TIMER_PRESCALE_EN
    chk("ps_read", rd, 32'd3);
`else
    chk("ps_read", rd, 32'd0);
`endif
    wr(4'd0, 32'h1);
    for (int j = 1; j <= 12; j++) begin
      rdv(4'd2, rd);
`ifdef TIMER_PRESCALE_EN
      chk("ps_step", rd, 32'((j - 1) / 4));
`else
      chk("ps_step", rd, 32'(j - 1));
`endif
    end
    wr(4'd0, 32'd0); wr(4'd3, 32'd0);

    // ---- randomized traffic ----
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 99) < 40) begin
        idle();
      end else begin
        ra = 4'($urandom_range(0, 15));
        rw = 1'($urandom_range(0, 1));
        rs = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        ci = $urandom_range(0, 3);
        case (ra)
          4'd0: rdv_d = {24'd0, 4'($urandom), 3'd0, 1'($urandom_range(0, 3) != 0)};
          4'd2: rdv_d = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 3))
                                                    : m_cmp[ci] - 32'($urandom_range(1, 6));
          4'd3: rdv_d = 32'($urandom_range(0, 3));
          4'd4, 4'd5, 4'd6, 4'd7: rdv_d = m_count + 32'($urandom_range(1, 8));
          4'd8, 4'd9, 4'd10, 4'd11: rdv_d = 32'($urandom_range(0, 4));
          default: rdv_d = $urandom;
        endcase
        step(1'b1, rw, ra, rdv_d, rs, rd);
      end
    end

    // ---- reset with a strobe in flight ----
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd2; sel = 4'hF;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("inflight_ack", {31'd0, ack}, 32'd0);
    chk("inflight_dat", rdat, 32'd0);
    chk("inflight_irq", {28'd0, irq}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle();
    for (int i = 0; i < 12; i++) begin
      rdv(4'(i), rd);
      chk("post_rst_reg", rd, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
